// File: rtl/wb_host_master.sv
// wb_host_master: valid/ready command stream to
// single Wishbone classic cycles, one response each.
module wb_host_master #(
  parameter int unsigned TMO_CYCLES = 256,
  parameter int unsigned TMO_W      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [3:0]  req_sel_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_tmo_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_RESP
  } state_t;

  localparam logic [TMO_W-1:0] LP_TMO_LAST =
    TMO_W'(TMO_CYCLES - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_req_ready, w_req_ready_nxt;
  logic               r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0]        r_rsp_dat,   w_rsp_dat_nxt;
  logic               r_rsp_err,   w_rsp_err_nxt;
  logic               r_rsp_tmo,   w_rsp_tmo_nxt;
  logic               r_cyc,       w_cyc_nxt;
  logic               r_we,        w_we_nxt;
  logic [3:0]         r_sel,       w_sel_nxt;
  logic [31:0]        r_adr,       w_adr_nxt;
  logic [31:0]        r_dat,       w_dat_nxt;
  logic [TMO_W-1:0]   r_cnt,       w_cnt_nxt;
  logic               w_bus_exit;

  // next-state and next-output decode for the transaction FSM
  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = r_req_ready;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_tmo_nxt   = r_rsp_tmo;
    w_cyc_nxt       = r_cyc;
    w_we_nxt        = r_we;
    w_sel_nxt       = r_sel;
    w_adr_nxt       = r_adr;
    w_dat_nxt       = r_dat;
    w_cnt_nxt       = r_cnt;
    w_bus_exit      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (r_req_ready && req_valid_i) begin
          w_we_nxt        = req_we_i;
          w_sel_nxt       = req_sel_i;
          w_adr_nxt       = req_adr_i;
          w_dat_nxt       = req_dat_i;
          w_cyc_nxt       = 1'b1;
          w_cnt_nxt       = '0;
          w_req_ready_nxt = 1'b0;
          w_state_nxt     = S_BUS;
        end
      end
      S_BUS: begin
        if (wbm_err_i) begin
          w_rsp_err_nxt = 1'b1;
          w_rsp_tmo_nxt = 1'b0;
          w_rsp_dat_nxt = '0;
          w_bus_exit    = 1'b1;
        end else if (wbm_ack_i) begin
          w_rsp_err_nxt = 1'b0;
          w_rsp_tmo_nxt = 1'b0;
          w_rsp_dat_nxt = r_we ? '0 : wbm_dat_i;
          w_bus_exit    = 1'b1;
        end else if (r_cnt == LP_TMO_LAST) begin
          w_rsp_err_nxt = 1'b0;
          w_rsp_tmo_nxt = 1'b1;
          w_rsp_dat_nxt = '0;
          w_bus_exit    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        if (w_bus_exit) begin
          w_cyc_nxt       = 1'b0;
          w_we_nxt        = 1'b0;
          w_sel_nxt       = '0;
          w_adr_nxt       = '0;
          w_dat_nxt       = '0;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          w_rsp_valid_nxt = 1'b0;
          w_rsp_dat_nxt   = '0;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_tmo_nxt   = 1'b0;
          w_req_ready_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_cyc_nxt       = 1'b0;
      end
    endcase
  end

  // state and output registers, synchronous reset
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_tmo   <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_tmo   <= w_rsp_tmo_nxt;
      r_cyc       <= w_cyc_nxt;
      r_we        <= w_we_nxt;
      r_sel       <= w_sel_nxt;
      r_adr       <= w_adr_nxt;
      r_dat       <= w_dat_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign req_ready_o = r_req_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign rsp_tmo_o   = r_rsp_tmo;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;

endmodule

// File: tb/tb_wb_host_master.sv
// tb_wb_host_master: directed bench for the
// Wishbone host master, timeout set to 8 cycles.
module tb_wb_host_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_adr, req_dat;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err, rsp_tmo;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;
  logic        ack, err;

  int n_chk = 0;
  int n_err = 0;

  wb_host_master #(
    .TMO_CYCLES(8),
    .TMO_W(16)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_we_i(req_we),
    .req_sel_i(req_sel),
    .req_adr_i(req_adr),
    .req_dat_i(req_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .rsp_tmo_o(rsp_tmo),
    .wbm_cyc_o(cyc),
    .wbm_stb_o(stb),
    .wbm_we_o(we),
    .wbm_sel_o(sel),
    .wbm_adr_o(adr),
    .wbm_dat_o(dat_o),
    .wbm_dat_i(dat_i),
    .wbm_ack_i(ack),
    .wbm_err_i(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic issue(input logic w,
                       input logic [3:0] s,
                       input logic [31:0] a,
                       input logic [31:0] d);
    chk("acc_rdy", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = w;
    req_sel   = s;
    req_adr   = a;
    req_dat   = d;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_sel   = 4'h0;
    req_adr   = 32'h0;
    req_dat   = 32'h0;
    chk("acc_cyc", {30'd0, cyc, stb}, 32'd3);
  endtask

  // ack_c: bus cycle carrying ack/err (0 = silent)
  task automatic bus_run(input int ack_c,
                         input logic use_ack,
                         input logic use_err,
                         input logic [31:0] d,
                         output int cyc_cnt);
    cyc_cnt = cyc ? 1 : 0;
    for (int c = 1; c <= 20 && cyc; c++) begin
      ack   = use_ack && (c == ack_c);
      err   = use_err && (c == ack_c);
      dat_i = (c == ack_c) ? d : 32'h0;
      tick();
      if (cyc) cyc_cnt++;
    end
    ack   = 1'b0;
    err   = 1'b0;
    dat_i = 32'h0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("cons_vld", {31'd0, rsp_valid}, 32'd0);
    chk("cons_rdy", {31'd0, req_ready}, 32'd1);
  endtask

  int ncyc;
  int bad;
  int n_c, n_v, first_acc, second_acc;

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_sel   = 4'h0;
    req_adr   = 32'h0;
    req_dat   = 32'h0;
    rsp_ready = 1'b0;
    dat_i     = 32'h0;
    ack       = 1'b0;
    err       = 1'b0;
    tick();
    tick();
    chk("rst_rdy", {31'd0, req_ready}, 32'd0);
    chk("rst_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("rst_vld", {31'd0, rsp_valid}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    rst = 1'b0;
    tick();
    chk("rel_rdy", {31'd0, req_ready}, 32'd1);

    // read, ack on 3rd bus cycle
    issue(1'b0, 4'hF, 32'h3000_0010, 32'h0);
    chk("rd_we", {31'd0, we}, 32'd0);
    chk("rd_adr", adr, 32'h3000_0010);
    chk("rd_sel", {28'd0, sel}, 32'hF);
    bus_run(3, 1'b1, 1'b0, 32'hDEAD_BEEF, ncyc);
    chk("rd_len", ncyc, 32'd3);
    chk("rd_vld", {31'd0, rsp_valid}, 32'd1);
    chk("rd_dat", rsp_dat, 32'hDEAD_BEEF);
    chk("rd_et", {30'd0, rsp_err, rsp_tmo}, 32'd0);
    chk("rd_adr0", adr, 32'd0);
    consume();
    chk("cons_dat", rsp_dat, 32'd0);

    // back-to-back zero-wait writes
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_sel   = 4'h3;
    req_adr   = 32'h3000_0004;
    req_dat   = 32'h1234_5678;
    rsp_ready = 1'b1;
    ack       = 1'b1;
    dat_i     = 32'hFFFF_FFFF;
    n_c = 0; n_v = 0;
    first_acc = 0; second_acc = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (cyc) begin
        n_c++;
        if (first_acc == 0) first_acc = i;
        else if (second_acc == 0) second_acc = i;
      end
      if (rsp_valid) n_v++;
      if (i == 1) begin
        chk("wr_dat", dat_o, 32'h1234_5678);
        chk("wr_sel", {28'd0, sel}, 32'h3);
        chk("wr_we", {31'd0, we}, 32'd1);
      end
      if (i == 2) begin
        chk("wr_vld", {31'd0, rsp_valid}, 32'd1);
        chk("wr_rdat", rsp_dat, 32'd0);
        chk("wr_cyc0", {31'd0, cyc}, 32'd0);
      end
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    ack       = 1'b0;
    rsp_ready = 1'b0;
    dat_i     = 32'h0;
    chk("b2b_cyc", n_c, 32'd3);
    chk("b2b_vld", n_v, 32'd3);
    chk("b2b_gap", second_acc - first_acc, 32'd3);
    chk("b2b_rdy", {31'd0, req_ready}, 32'd1);

    // ack and err together on cycle 2
    issue(1'b0, 4'hF, 32'h3000_0020, 32'h0);
    bus_run(2, 1'b1, 1'b1, 32'hAAAA_5555, ncyc);
    chk("ae_len", ncyc, 32'd2);
    chk("ae_err", {31'd0, rsp_err}, 32'd1);
    chk("ae_dat", rsp_dat, 32'd0);
    chk("ae_tmo", {31'd0, rsp_tmo}, 32'd0);
    consume();

    // err only
    issue(1'b0, 4'hF, 32'h3000_0024, 32'h0);
    bus_run(1, 1'b0, 1'b1, 32'h5555_AAAA, ncyc);
    chk("er_err", {31'd0, rsp_err}, 32'd1);
    chk("er_dat", rsp_dat, 32'd0);
    consume();

    // timeout with silent slave, then stray ack
    issue(1'b0, 4'hF, 32'h3000_0030, 32'h0);
    bus_run(0, 1'b0, 1'b0, 32'h0, ncyc);
    chk("to_len", ncyc, 32'd8);
    chk("to_tmo", {31'd0, rsp_tmo}, 32'd1);
    chk("to_err", {31'd0, rsp_err}, 32'd0);
    chk("to_vld", {31'd0, rsp_valid}, 32'd1);
    ack   = 1'b1;
    dat_i = 32'h0000_0055;
    tick();
    ack   = 1'b0;
    dat_i = 32'h0;
    chk("to9_tmo", {31'd0, rsp_tmo}, 32'd1);
    chk("to9_dat", rsp_dat, 32'd0);
    chk("to9_cyc", {31'd0, cyc}, 32'd0);
    consume();

    // ack on the 8th edge wins over timeout
    issue(1'b0, 4'hF, 32'h3000_0034, 32'h0);
    bus_run(8, 1'b1, 1'b0, 32'h8888_0008, ncyc);
    chk("a8_len", ncyc, 32'd8);
    chk("a8_tmo", {31'd0, rsp_tmo}, 32'd0);
    chk("a8_dat", rsp_dat, 32'h8888_0008);
    consume();

    // response backpressure for 20 cycles
    issue(1'b0, 4'hF, 32'h3000_0040, 32'h0);
    bus_run(1, 1'b1, 1'b0, 32'hCAFE_F00D, ncyc);
    req_valid = 1'b1;
    req_adr   = 32'h3000_0044;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b1 ||
          rsp_dat !== 32'hCAFE_F00D ||
          req_ready !== 1'b0 ||
          cyc !== 1'b0) bad++;
    end
    req_valid = 1'b0;
    req_adr   = 32'h0;
    chk("bp_stable", bad, 32'd0);
    consume();

    // reset during cycle 2 of a read
    issue(1'b0, 4'hF, 32'h3000_0050, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("rb_cyc", {30'd0, cyc, stb}, 32'd0);
    chk("rb_vld", {31'd0, rsp_valid}, 32'd0);
    chk("rb_rdy", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    ack = 1'b1;
    tick();
    chk("rb_rdy1", {31'd0, req_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== 1'b0) bad++;
    end
    ack = 1'b0;
    chk("rb_norsp", bad, 32'd0);

    // reset while a response is pending
    issue(1'b0, 4'hF, 32'h3000_0060, 32'h0);
    bus_run(1, 1'b1, 1'b0, 32'h1111_2222, ncyc);
    chk("rr_vld1", {31'd0, rsp_valid}, 32'd1);
    rst = 1'b1;
    tick();
    chk("rr_vld0", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rr_rdy", {31'd0, req_ready}, 32'd1);
    chk("rr_vld", {31'd0, rsp_valid}, 32'd0);

    // next read after reset completes
    issue(1'b0, 4'hF, 32'h3000_0070, 32'h0);
    bus_run(2, 1'b1, 1'b0, 32'h0BAD_F00D, ncyc);
    chk("nx_len", ncyc, 32'd2);
    chk("nx_dat", rsp_dat, 32'h0BAD_F00D);
    chk("nx_et", {30'd0, rsp_err, rsp_tmo}, 32'd0);
    consume();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wb_host_master.md
Name: wb_host_master

Overview:
- Wishbone classic-cycle initiator, 32-bit data.
- Converts a simple valid/ready command stream into single read/write bus cycles on an internal Wishbone.
- Returns one response per command: data plus error or timeout status.
- Counterpart of the management-SoC slave port into digital_core. Used by on-chip agents (UART/SPI debug bridges, LA-driven test access) to drive the same internal bus the management SoC drives.

Parameters:
- TMO_CYCLES, 256, bus cycles allowed per transaction before timeout (legal range 2..65535).
- TMO_W, 16, width of the timeout counter; must satisfy 2^TMO_W > TMO_CYCLES.

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  command accepted when valid&ready at a clock edge.
- req_we_i  in  1  1=write, 0=read.
- req_sel_i  in  4  byte selects.
- req_adr_i  in  32  byte address.
- req_dat_i  in  32  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready at a clock edge.
- rsp_dat_o  out  32  read data (0 for writes, errors and timeouts).
- rsp_err_o  out  1  slave signalled err.
- rsp_tmo_o  out  1  no ack/err within TMO_CYCLES.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.
- wbm_err_i  in  1  Wishbone error.

Behaviour:
- All outputs registered.
- Reset values: req_ready_o=0; all other outputs 0; state=IDLE; timeout counter=0.
- req_ready_o is 1 in IDLE only, from the first cycle after reset release.
- FSM states: IDLE, BUS, RESP. One outstanding transaction; no pipelining.
- IDLE:
  - On edge with req_valid_i=1, latch we/sel/adr/dat into the wbm_* outputs.
  - At the same edge: cyc=stb=1, counter=0, req_ready_o=0, go to BUS.
  - req_* inputs are ignored outside the accept edge.
- BUS:
  - cyc/stb/we/sel/adr/dat held stable.
  - Counter increments each edge without ack/err.
  - Edge with wbm_err_i=1: rsp_err_o=1, rsp_tmo_o=0, rsp_dat_o=0, go to RESP. err has priority over a simultaneous ack.
  - Edge with wbm_ack_i=1 and err=0: rsp_err_o=0, rsp_tmo_o=0. rsp_dat_o=wbm_dat_i for a read, 0 for a write. Go to RESP.
  - Edge with no ack/err and counter==TMO_CYCLES-1: rsp_tmo_o=1, rsp_err_o=0, rsp_dat_o=0, go to RESP.
  - An ack or err at that same edge wins over timeout.
  - On every exit from BUS: cyc=stb=0 at the exit edge and rsp_valid_o=1. cyc is therefore high for at most TMO_CYCLES cycles.
  - On exit, we/sel/adr/dat outputs return to 0.
- RESP:
  - rsp_valid_o and rsp_* held stable until an edge with rsp_ready_i=1.
  - At that edge: rsp_valid_o=0, rsp_* fields cleared to 0, req_ready_o=1, go to IDLE.
  - Backpressure is unbounded.
- Latency: command accepted at edge k, with ack on the first bus cycle:
  - cyc/stb high for exactly one cycle (k..k+1);
  - rsp_valid_o high after edge k+1.
  - Next command can be accepted at the edge after response consumption; minimum 3 cycles per transaction.
- wbm_ack_i and wbm_err_i are ignored outside BUS; stray acks cause no state change.
- Reset mid-operation (any state): at the reset edge cyc/stb drop and rsp_valid drops. Any pending response is discarded; no response is ever emitted for it.
- Counter saturates-free: it never exceeds TMO_CYCLES-1 because timeout forces the exit.

Test Plan:
- Read, ack on 3rd bus cycle. req adr=0x3000_0010, sel=0xF, wbm_dat_i=0xDEAD_BEEF -> cyc/stb high exactly 3 cycles, we=0. Response dat=0xDEADBEEF, err=0, tmo=0.
- Write with zero-wait ack, rsp_ready_i tied 1. adr=0x3000_0004, dat=0x1234_5678, sel=0x3 -> wbm_dat_o/sel_o match for 1 cycle, rsp_valid 1 cycle, rsp_dat=0. Back-to-back commands accepted every 3 cycles.
- Error precedence. Assert ack and err together on cycle 2 -> rsp_err=1, dat=0. Separate run with only err -> rsp_err=1.
- Timeout, TMO_CYCLES=8, slave silent -> cyc high exactly 8 cycles, rsp_tmo=1. Ack arriving on the 8th edge -> normal response, tmo=0. Ack on the 9th edge -> ignored.
- Response backpressure. Hold rsp_ready_i=0 for 20 cycles after a read -> rsp_valid and rsp_dat stable, req_ready_o=0, no new bus cycle despite req_valid_i=1.
- Reset mid-BUS (cycle 2 of a read) and mid-RESP -> cyc/stb/rsp_valid=0 after the reset edge. No response emitted. req_ready_o=1 one cycle after reset release; the next read completes correctly.
